// File: rtl/divider_pkg.sv
// Shared definitions for the 32-bit restoring divider: width, FSM encoding
// and the quotient reported for a zero divisor.
package divider_pkg;
  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_subtractor_32bit.sv
// 32-bit adder/subtractor: subt_signal=1 computes a - b as a + ~b + 1;
// carry_out=1 on subtraction means no borrow occurred.
module adder_subtractor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        subt_signal,
  output logic [31:0] result,
  output logic        carry_out
);
  logic [31:0] b_eff;

  assign b_eff = b ^ {32{subt_signal}};
  assign {carry_out, result} = {1'b0, a} + {1'b0, b_eff} + {32'd0, subt_signal};
endmodule

// File: rtl/divider_32bit.sv
// Sequential unsigned divider: one restoring shift/subtract step per clock,
// 32 iterations per operation, with a short path for a zero divisor.
module divider_32bit #(
  parameter int WIDTH = divider_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  import divider_pkg::*;

  state_t           state, state_nxt;
  logic [5:0]       cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] divisor_r;

  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] qreg_nxt;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             trial_ok;
  logic             zero_div;
  logic             last_iter;

  assign shifted_rem = {prem[WIDTH-1:0], qreg[WIDTH-1]};

  adder_subtractor_32bit u_trial_sub (
    .a           (shifted_rem[WIDTH-1:0]),
    .b           (divisor_r),
    .subt_signal (1'b1),
    .result      (diff),
    .carry_out   (carry)
  );

  // A set bit 32 means the shifted remainder already exceeds any 32-bit divisor.
  assign trial_ok  = shifted_rem[WIDTH] | carry;
  assign rem_nxt   = trial_ok ? {1'b0, diff} : shifted_rem;
  assign qreg_nxt  = {qreg[WIDTH-2:0], trial_ok};
  assign zero_div  = (divisor_r == '0);
  assign last_iter = (cnt == 6'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (zero_div || last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero divisor spends a single RUN cycle; qreg still holds the dividend then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      prem        <= '0;
      qreg        <= '0;
      divisor_r   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            divisor_r <= divisor;
            prem      <= '0;
            qreg      <= dividend;
            cnt       <= '0;
          end
        end
        RUN: begin
          if (zero_div) begin
            quotient    <= DIV_ZERO_QUOTIENT;
            remainder   <= qreg;
            div_by_zero <= 1'b1;
          end else begin
            prem <= rem_nxt;
            qreg <= qreg_nxt;
            cnt  <= cnt + 6'd1;
            if (last_iter) begin
              quotient    <= qreg_nxt;
              remainder   <= rem_nxt[WIDTH-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_32bit.sv
// Self-checking bench for divider_32bit: cycle-level behavioural model,
// directed literal cases and randomized operand pairs.
module tb_divider_32bit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  divider_32bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Model: cycles left until done, plus the results the operation must produce.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0;
  bit          m_z = 1'b0;
  logic [31:0] p_q = '0, p_r = '0;
  bit          p_z = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z;
      end
    end else if (start) begin
      if (divisor == 32'd0) begin
        p_q = 32'hFFFF_FFFF; p_r = dividend; p_z = 1'b1; m_left = 1;
      end else begin
        p_q = dividend / divisor; p_r = dividend % divisor; p_z = 1'b0; m_left = 32;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_left > 0 || m_done));
    check("done", 64'(done), 64'(m_done));
    check("quotient", 64'(quotient), 64'(m_q));
    check("remainder", 64'(remainder), 64'(m_r));
    check("div_by_zero", 64'(div_by_zero), 64'(m_z));
    if (done) done_cnt++;
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while ((m_left > 0 || m_done) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(input int exp_lat);
    int lat = -1;
    for (int i = 0; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_lit(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input bit ez);
    start_op(a, b);
    wait_done((b == 32'd0) ? 1 : 32);
    check("lit_quotient", 64'(quotient), 64'(eq));
    check("lit_remainder", 64'(remainder), 64'(er));
    check("lit_div_by_zero", 64'(div_by_zero), 64'(ez));
    @(negedge clk);
    check("lit_busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b, q, r;
    logic [63:0] prod;
    int dc0;

    repeat (2) @(negedge clk);
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_remainder", 64'(remainder), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_lit(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_lit(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_lit(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_lit(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_lit(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Second start during RUN must be dropped.
    dc0 = done_cnt;
    start_op(32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    dividend = 32'd9; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(27);
    check("ignored_start_quotient", 64'(quotient), 64'd333);
    check("ignored_start_remainder", 64'(remainder), 64'd1);
    repeat (40) @(negedge clk);
    check("single_done_pulse", 64'(done_cnt - dc0), 64'd1);

    // Reset in the middle of RUN.
    dc0 = done_cnt;
    start_op(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_quotient", 64'(quotient), 64'd0);
    check("midrun_reset_remainder", 64'(remainder), 64'd0);
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_done", 64'(done), 64'd0);
    check("midrun_reset_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midrun_reset_no_done", 64'(done_cnt - dc0), 64'd0);
    run_lit(32'd7, 32'd9, 32'd0, 32'd7, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = a >> $urandom_range(0, 31);
        default: b = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      start_op(a, b);
      wait_done((b == 32'd0) ? 1 : 32);
      q = quotient;
      r = remainder;
      if (b != 32'd0) begin
        prod = 64'(q) * 64'(b) + 64'(r);
        check("rand_identity", prod, 64'(a));
        check("rand_rem_lt_div", 64'(r < b), 64'd1);
      end else begin
        check("rand_zero_quotient", 64'(q), 64'hFFFF_FFFF);
        check("rand_zero_remainder", 64'(r), 64'(a));
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
